data_bus_interconnect: RTL and testbench

DATA_BUS_INTERCONNECT -- requirements
Module: data_bus_interconnect

---
 rtl/data_bus_interconnect_if.sv | 39 +++
 rtl/data_bus_interconnect.sv | 121 ++++++++++++
 tb/tb_data_bus_interconnect.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_interconnect_if.sv
// data_bus_interconnect_if: core request/response channel plus the per-slave fan-out bundle
interface data_bus_interconnect_if #(
    parameter int NUM_SLAVES = 8
);
    logic                        core_req;
    logic                        core_we;
    logic [3:0]                  core_be;
    logic [31:0]                 core_addr;
    logic [31:0]                 core_wdata;
    logic                        core_gnt;
    logic                        core_rvalid;
    logic                        core_err;
    logic [31:0]                 core_rdata;
    logic [NUM_SLAVES-1:0]       slv_req;
    logic [NUM_SLAVES-1:0]       slv_we;
    logic [NUM_SLAVES-1:0][3:0]  slv_be;
    logic [NUM_SLAVES-1:0][31:0] slv_addr;
    logic [NUM_SLAVES-1:0][31:0] slv_wdata;
    logic [NUM_SLAVES-1:0]       slv_gnt;
    logic [NUM_SLAVES-1:0]       slv_rvalid;
    logic [NUM_SLAVES-1:0]       slv_err;
    logic [NUM_SLAVES-1:0][31:0] slv_rdata;

    // interconnect side: serves the core, drives the slave request lines
    modport slave (
        input  core_req, core_we, core_be, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_err, core_rdata,
        output slv_req, slv_we, slv_be, slv_addr, slv_wdata,
        input  slv_gnt, slv_rvalid, slv_err, slv_rdata
    );

    // environment side: the core master and the slave devices
    modport master (
        output core_req, core_we, core_be, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_err, core_rdata,
        input  slv_req, slv_we, slv_be, slv_addr, slv_wdata,
        output slv_gnt, slv_rvalid, slv_err, slv_rdata
    );
endinterface

// File: rtl/data_bus_interconnect.sv
// data_bus_interconnect: address-decoded 1-to-N bus fabric with in-order response tracking.
// Define DATA_BUS_GNT_TIMEOUT_EN to enable the grant-wait watchdog (GNT_TIMEOUT cycles).
module data_bus_interconnect #(
    parameter int                          NUM_SLAVES      = 8,
    parameter int                          MAX_OUTSTANDING = 2,
    parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_BASE      = '0,
    parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_MASK      = '0,
    parameter int                          GNT_TIMEOUT     = 255
) (
    input logic                    clk,
    input logic                    rst_n,
    data_bus_interconnect_if.slave bus
);
    localparam int IDW = $clog2(NUM_SLAVES + 1);
    localparam int SW  = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    localparam int PW  = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [IDW-1:0] ERR_ID   = IDW'(NUM_SLAVES);
    localparam logic [PW-1:0]  LAST_PTR = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(MAX_OUTSTANDING);

    logic [IDW-1:0] fifo [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [IDW-1:0] last_id;
    logic [IDW-1:0] tgt;
    logic [IDW-1:0] head;
    logic [IDW-1:0] push_id;
    logic [SW-1:0]  sel;
    logic [SW-1:0]  hsel;
    logic           empty;
    logic           stall;
    logic           raw_gnt;
    logic           tmo;
    logic           push;
    logic           pop;
    logic           head_err;

`ifdef DATA_BUS_GNT_TIMEOUT_EN
    localparam int TW = GNT_TIMEOUT > 0 ? $clog2(GNT_TIMEOUT + 1) : 1;
    logic [TW-1:0] tmo_cnt;
`endif

    // address decode: lowest-index hit wins, no hit targets the error responder
    always_comb begin
        tgt = ERR_ID;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if ((bus.core_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) tgt = IDW'(i);
    end

    // grant gating against the tracking FIFO and response routing from its head
    always_comb begin
        sel = tgt[SW-1:0];
        empty = count == '0;
        stall = count == FULL_CNT || (!empty && last_id != tgt);
        raw_gnt = tgt == ERR_ID || bus.slv_gnt[sel];
`ifdef DATA_BUS_GNT_TIMEOUT_EN
        tmo = bus.core_req && !stall && !raw_gnt && tmo_cnt == TW'(GNT_TIMEOUT);
`else
        tmo = GNT_TIMEOUT < 0;
`endif
        bus.core_gnt = bus.core_req && !stall && (raw_gnt || tmo);
        push = bus.core_gnt;
        push_id = tmo ? ERR_ID : tgt;
        head = fifo[rd_ptr];
        hsel = head[SW-1:0];
        head_err = !empty && head == ERR_ID;
        bus.core_rvalid = !empty && (head_err || bus.slv_rvalid[hsel]);
        bus.core_err = !empty && (head_err || bus.slv_err[hsel]);
        bus.core_rdata = (empty || head_err) ? '0 : bus.slv_rdata[hsel];
        pop = bus.core_rvalid;
    end

    // only the decoded slave sees the request and payload, and only when not held off
    always_comb begin
        bus.slv_req = '0;
        bus.slv_we = '0;
        bus.slv_be = '0;
        bus.slv_addr = '0;
        bus.slv_wdata = '0;
        if (!stall && !tmo && tgt != ERR_ID) begin
            bus.slv_req[sel] = bus.core_req;
            bus.slv_we[sel] = bus.core_we;
            bus.slv_be[sel] = bus.core_be;
            bus.slv_addr[sel] = bus.core_addr;
            bus.slv_wdata[sel] = bus.core_wdata;
        end
    end

    // FIFO pointers, occupancy and the most recently pushed target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            last_id <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr == LAST_PTR ? '0 : wr_ptr + 1'b1;
                last_id <= push_id;
            end
            if (pop) rd_ptr <= rd_ptr == LAST_PTR ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO entry storage; validity is tracked by the occupancy counter
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= push_id;
    end

`ifdef DATA_BUS_GNT_TIMEOUT_EN
    // count cycles an unstalled request waits for its grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt <= '0;
        else if (!bus.core_req || bus.core_gnt) tmo_cnt <= '0;
        else if (!stall) tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_data_bus_interconnect.sv
// tb_data_bus_interconnect: directed scenarios plus randomized traffic against a queue-based model
module tb_data_bus_interconnect;
    localparam int NS  = 3;
    localparam int MO  = 2;
    localparam int TO  = 4;
    localparam int ERR = NS;
    localparam logic [NS-1:0][31:0] BASE = {32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NS-1:0][31:0] MASK = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_bad = 0;
    int q[$];
    int waited = 0;
    int pending [NS] = '{default: 0};
    bit exp_push;
    bit exp_pop;
    bit taken;
    int exp_id;
    logic [NS-1:0] accepted;

    data_bus_interconnect_if #(.NUM_SLAVES(NS)) bus ();

    data_bus_interconnect #(
        .NUM_SLAVES(NS),
        .MAX_OUTSTANDING(MO),
        .SLAVE_BASE(BASE),
        .SLAVE_MASK(MASK),
        .GNT_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // memory map of this bench: slave0 64K at 0, slave1 64K above it, slave2 the rest below 0x1000_0000
    function automatic int target_of(input logic [31:0] a);
        if (a < 32'h0001_0000) return 0;
        if (a < 32'h0002_0000) return 1;
        if (a < 32'h1000_0000) return 2;
        return ERR;
    endfunction

    task automatic idle();
        bus.core_req = 1'b0;
        bus.core_we = 1'b0;
        bus.core_be = '0;
        bus.core_addr = '0;
        bus.core_wdata = '0;
        bus.slv_gnt = '0;
        bus.slv_rvalid = '0;
        bus.slv_err = '0;
        bus.slv_rdata = '0;
    endtask

    task automatic settle();
        int t;
        int h;
        bit stall;
        bit raw;
        bit tmo;
        bit g;
        bit hv;
        bit sel;
        logic [NS-1:0] sreq;
        @(negedge clk);
        t = target_of(bus.core_addr);
        stall = q.size() == MO || (q.size() > 0 && q[$] != t);
        raw = t == ERR ? 1'b1 : bus.slv_gnt[t];
        tmo = 1'b0;
`ifdef DATA_BUS_GNT_TIMEOUT_EN
        tmo = bus.core_req && !stall && !raw && waited == TO;
`endif
        g = bus.core_req && !stall && (raw || tmo);
        hv = q.size() > 0;
        h = hv ? q[0] : 0;
        exp_pop = hv && (h == ERR || bus.slv_rvalid[h]);
        chk("core_gnt", 32'(bus.core_gnt), 32'(g));
        chk("core_rvalid", 32'(bus.core_rvalid), 32'(exp_pop));
        chk("core_err", 32'(bus.core_err), 32'(hv && (h == ERR || bus.slv_err[h])));
        chk("core_rdata", bus.core_rdata, (!hv || h == ERR) ? 32'h0 : bus.slv_rdata[h]);
        sreq = '0;
        for (int j = 0; j < NS; j++) begin
            sel = !stall && !tmo && t == j;
            if (sel) sreq[j] = bus.core_req;
            chk("slv_addr", bus.slv_addr[j], sel ? bus.core_addr : 32'h0);
            chk("slv_wdata", bus.slv_wdata[j], sel ? bus.core_wdata : 32'h0);
            chk("slv_we_be", 32'({bus.slv_we[j], bus.slv_be[j]}), sel ? 32'({bus.core_we, bus.core_be}) : 32'h0);
        end
        chk("slv_req", 32'(bus.slv_req), 32'(sreq));
        exp_push = g;
        exp_id = tmo ? ERR : t;
        taken = bus.core_req && bus.core_gnt;
        accepted = bus.slv_req & bus.slv_gnt;
        if (!rst_n || !bus.core_req || g) waited = 0;
        else if (!stall) waited++;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            if (exp_pop) void'(q.pop_front());
            if (exp_push) q.push_back(exp_id);
        end
        for (int j = 0; j < NS; j++) begin
            if (accepted[j]) pending[j]++;
            if (bus.slv_rvalid[j] && pending[j] > 0) pending[j]--;
        end
        #1;
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        q.delete();
        waited = 0;
    endtask

    initial begin
        int r;
        idle();
        enter_reset();
        repeat (2) begin settle(); advance(); end
        rst_n = 1'b1;
        // single read to slave0, response next cycle
        bus.core_req = 1'b1;
        bus.core_addr = 32'h0000_0010;
        bus.slv_gnt = '1;
        settle();
        chk("rd_gnt", 32'(bus.core_gnt), 32'h1);
        chk("rd_slv_req", 32'(bus.slv_req), 32'h1);
        advance();
        bus.core_req = 1'b0;
        bus.slv_rvalid = 3'b001;
        bus.slv_rdata[0] = 32'hDEAD_BEEF;
        settle();
        chk("rd_rvalid", 32'(bus.core_rvalid), 32'h1);
        chk("rd_rdata", bus.core_rdata, 32'hDEAD_BEEF);
        chk("rd_err", 32'(bus.core_err), 32'h0);
        advance();
        bus.slv_rvalid = '0;
        // unmapped address answered by the error responder
        bus.core_req = 1'b1;
        bus.core_addr = 32'h8000_0000;
        settle();
        chk("err_gnt", 32'(bus.core_gnt), 32'h1);
        chk("err_no_slv_req", 32'(bus.slv_req), 32'h0);
        advance();
        bus.core_req = 1'b0;
        settle();
        chk("err_rvalid", 32'(bus.core_rvalid), 32'h1);
        chk("err_err", 32'(bus.core_err), 32'h1);
        chk("err_rdata", bus.core_rdata, 32'h0);
        advance();
        settle();
        chk("err_once", 32'(bus.core_rvalid), 32'h0);
        advance();
        // three back-to-back reads with two slots
        bus.core_req = 1'b1;
        bus.core_addr = 32'h20;
        settle();
        chk("b2b_gnt1", 32'(bus.core_gnt), 32'h1);
        advance();
        bus.core_addr = 32'h24;
        settle();
        chk("b2b_gnt2", 32'(bus.core_gnt), 32'h1);
        advance();
        bus.core_addr = 32'h28;
        settle();
        chk("b2b_full_gnt", 32'(bus.core_gnt), 32'h0);
        chk("b2b_full_req", 32'(bus.slv_req), 32'h0);
        advance();
        bus.slv_rvalid = 3'b001;
        settle();
        chk("b2b_pop_full_gnt", 32'(bus.core_gnt), 32'h0);
        chk("b2b_pop_rvalid", 32'(bus.core_rvalid), 32'h1);
        advance();
        bus.slv_rvalid = '0;
        settle();
        chk("b2b_gnt3", 32'(bus.core_gnt), 32'h1);
        chk("b2b_req3", 32'(bus.slv_req), 32'h1);
        advance();
        bus.core_req = 1'b0;
        bus.slv_rvalid = 3'b001;
        repeat (2) begin settle(); chk("b2b_drain", 32'(bus.core_rvalid), 32'h1); advance(); end
        bus.slv_rvalid = '0;
        settle();
        chk("b2b_empty", 32'(bus.core_rvalid), 32'h0);
        advance();
        // switching slaves waits for the previous response
        bus.core_req = 1'b1;
        bus.core_addr = 32'h30;
        settle();
        chk("ord_gnt0", 32'(bus.core_gnt), 32'h1);
        advance();
        bus.core_addr = 32'h0001_0040;
        repeat (2) begin settle(); chk("ord_stall", 32'(bus.core_gnt), 32'h0); advance(); end
        bus.slv_rvalid = 3'b001;
        bus.slv_rdata[0] = 32'h1111_0000;
        settle();
        chk("ord_pop_gnt", 32'(bus.core_gnt), 32'h0);
        chk("ord_rdata0", bus.core_rdata, 32'h1111_0000);
        advance();
        bus.slv_rvalid = '0;
        settle();
        chk("ord_gnt1", 32'(bus.core_gnt), 32'h1);
        chk("ord_req1", 32'(bus.slv_req), 32'h2);
        advance();
        bus.core_req = 1'b0;
        bus.slv_rvalid = 3'b010;
        bus.slv_rdata[1] = 32'h2222_0001;
        settle();
        chk("ord_rvalid1", 32'(bus.core_rvalid), 32'h1);
        chk("ord_rdata1", bus.core_rdata, 32'h2222_0001);
        advance();
        bus.slv_rvalid = '0;
        // slave1 never grants
        bus.slv_gnt = 3'b101;
        bus.core_req = 1'b1;
        bus.core_addr = 32'h0001_0000;
`ifdef DATA_BUS_GNT_TIMEOUT_EN
        repeat (TO) begin settle(); chk("tmo_wait", 32'(bus.core_gnt), 32'h0); advance(); end
        settle();
        chk("tmo_gnt", 32'(bus.core_gnt), 32'h1);
        chk("tmo_no_req", 32'(bus.slv_req), 32'h0);
        advance();
        bus.core_req = 1'b0;
        settle();
        chk("tmo_rvalid", 32'(bus.core_rvalid), 32'h1);
        chk("tmo_err", 32'(bus.core_err), 32'h1);
        advance();
`else
        repeat (100) begin settle(); chk("nogrant_wait", 32'(bus.core_gnt), 32'h0); advance(); end
        bus.core_req = 1'b0;
        settle();
        advance();
`endif
        // reset with two outstanding entries, late response ignored
        bus.slv_gnt = '1;
        bus.core_req = 1'b1;
        bus.core_addr = 32'h40;
        repeat (2) begin settle(); advance(); end
        bus.core_req = 1'b0;
        enter_reset();
        settle();
        chk("rst_rvalid", 32'(bus.core_rvalid), 32'h0);
        advance();
        rst_n = 1'b1;
        bus.slv_rvalid = 3'b001;
        repeat (2) begin settle(); chk("rst_late_rvalid", 32'(bus.core_rvalid), 32'h0); advance(); end
        idle();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!bus.core_req || taken) begin
                bus.core_req = ($urandom % 4) != 0;
                r = int'($urandom % 4);
                bus.core_addr = r == 0 ? $urandom % 32'h1_0000 :
                                r == 1 ? 32'h1_0000 + $urandom % 32'h1_0000 :
                                r == 2 ? 32'h2_0000 + $urandom % 32'h0FFE_0000 :
                                         32'h1000_0000 + $urandom % 32'hF000_0000;
                bus.core_we = 1'($urandom);
                bus.core_be = 4'($urandom);
                bus.core_wdata = $urandom;
            end
            for (int j = 0; j < NS; j++) begin
                bus.slv_gnt[j] = j == 1 ? ($urandom % 6 == 0) : ($urandom % 3 != 0);
                bus.slv_rvalid[j] = pending[j] > 0 ? ($urandom % 2 == 0) : ($urandom % 16 == 0);
                bus.slv_err[j] = $urandom % 8 == 0;
                bus.slv_rdata[j] = $urandom;
            end
            if ($urandom % 250 == 0) enter_reset();
            else rst_n = 1'b1;
            settle();
            advance();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
